// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: the buffered result word and its width.
package alu_pkg;

    localparam int ALU_N = 4;
    localparam int SEL_W = 3;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             co;
        logic             zero;
        logic [ALU_N-1:0] s;
    } alu_res_t;

    // Word width of one buffered result for an n-bit ALU.
    function automatic int res_width(input int n);
        return SEL_W + 2 + n;
    endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer bus of the ALU result buffer; slave is the buffer itself.
interface alu_result_fifo_if
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic [N-1:0]             s;
    logic                     co;
    logic [SEL_W-1:0]         sel;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [N-1:0]             out_s;
    logic                     out_co;
    logic                     out_zero;
    logic [SEL_W-1:0]         out_sel;
    logic [$clog2(DEPTH):0]   count;
    logic                     ovf;
    logic                     ovf_clr;

    modport master (
        output in_valid, s, co, sel, out_ready, ovf_clr,
        input  in_ready, out_valid, out_s, out_co, out_zero, out_sel, count, ovf
    );

    modport slave (
        input  in_valid, s, co, sel, out_ready, ovf_clr,
        output in_ready, out_valid, out_s, out_co, out_zero, out_sel, count, ovf
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; full/empty come from the occupancy count, not pointer compare.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_result_fifo.sv
// Buffers ALU results with a derived zero flag; flags a sticky overflow on dropped pushes.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_fifo_if.slave   bus
);
    localparam int W = res_width(N);

    alu_res_t                 wr_res;
    alu_res_t                 head;
    logic [W-1:0]             rd_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     ovf_r;

    // Zero depends on s only; carry has no bearing on it.
    always_comb begin
        wr_res      = '0;
        wr_res.sel  = bus.sel;
        wr_res.co   = bus.co;
        wr_res.zero = (bus.s == '0);
        wr_res.s    = bus.s;
    end

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_data (wr_res),
        .rd_en   (bus.out_ready),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign head          = rd_data;
    assign bus.out_s     = head.s;
    assign bus.out_co    = head.co;
    assign bus.out_zero  = head.zero;
    assign bus.out_sel   = head.sel;
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.count     = count;
    assign bus.ovf       = ovf_r;

    // A drop outranks a same-cycle clear so no overflow event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (bus.in_valid && full) begin
            ovf_r <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]   sel;
        logic         co;
        logic [N-1:0] s;
    } ent_t;

    logic clk;
    logic rst;
    int   nchecks;
    int   nfail;
    ent_t mq[$];
    logic movf;

    alu_result_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

    alu_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; model follows the behavioural rules using pre-edge inputs.
    task automatic tick();
        bit   full_m, push_m, pop_m, drop_m;
        ent_t e;
        ent_t d;
        full_m = (mq.size() == DEPTH);
        push_m = bus.in_valid && !full_m;
        drop_m = bus.in_valid && full_m;
        pop_m  = bus.out_ready && (mq.size() > 0);
        e.sel  = bus.sel;
        e.co   = bus.co;
        e.s    = bus.s;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (pop_m) d = mq.pop_front();
            if (push_m) mq.push_back(e);
            if (drop_m) movf = 1'b1;
            else if (bus.ovf_clr) movf = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input logic iv, input logic [N-1:0] s, input logic co,
                         input logic [2:0] sel, input logic ordy, input logic clr);
        bus.in_valid  = iv;
        bus.s         = s;
        bus.co        = co;
        bus.sel       = sel;
        bus.out_ready = ordy;
        bus.ovf_clr   = clr;
        tick();
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        nchecks++;
        if (bus.count !== 3'd0) begin nfail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        nchecks++;
        if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        nchecks++;
        if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        nchecks++;
        if (bus.ovf !== 1'b0) begin nfail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        nchecks++;
        if ({bus.out_s, bus.out_co, bus.out_zero, bus.out_sel} !== '0) begin
            nfail++;
            $display("FAIL reset_head got s=%h co=%b z=%b sel=%h want all 0",
                     bus.out_s, bus.out_co, bus.out_zero, bus.out_sel);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 4'b0101, 1'b0, 3'b010, 1'b0, 1'b0);
        idle();
        nchecks++;
        if (bus.out_valid !== 1'b1) begin nfail++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        nchecks++;
        if (bus.out_s !== 4'b0101) begin nfail++; $display("FAIL single_s got %b want 0101", bus.out_s); end
        nchecks++;
        if (bus.out_zero !== 1'b0 || bus.out_co !== 1'b0 || bus.out_sel !== 3'b010) begin
            nfail++;
            $display("FAIL single_flags got z=%b co=%b sel=%b want 0 0 010", bus.out_zero, bus.out_co, bus.out_sel);
        end
        nchecks++;
        if (bus.count !== 3'd1) begin nfail++; $display("FAIL single_count got %0d want 1", bus.count); end
        drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
        idle();
        nchecks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL single_pop got count=%0d valid=%b want 0 0", bus.count, bus.out_valid);
        end
    endtask

    task automatic test_fill_ovf();
        logic [3:0] exp_s [4];
        exp_s[0] = 4'd0; exp_s[1] = 4'd1; exp_s[2] = 4'd2; exp_s[3] = 4'd3;
        for (int i = 0; i < 4; i++) drive(1'b1, exp_s[i], (i == 0), 3'(i), 1'b0, 1'b0);
        idle();
        nchecks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            nfail++;
            $display("FAIL fill_full got count=%0d in_ready=%b want 4 0", bus.count, bus.in_ready);
        end
        drive(1'b1, 4'b1111, 1'b0, 3'b111, 1'b0, 1'b0);
        idle();
        nchecks++;
        if (bus.ovf !== 1'b1 || bus.count !== 3'd4) begin
            nfail++;
            $display("FAIL fill_drop got ovf=%b count=%0d want 1 4", bus.ovf, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            nchecks++;
            if (bus.out_valid !== 1'b1 || bus.out_s !== exp_s[i] || bus.out_co !== (i == 0)
                || bus.out_zero !== (i == 0) || bus.out_sel !== 3'(i)) begin
                nfail++;
                $display("FAIL drain_%0d got v=%b s=%h co=%b z=%b sel=%h want 1 %h %b %b %h", i,
                         bus.out_valid, bus.out_s, bus.out_co, bus.out_zero, bus.out_sel,
                         exp_s[i], (i == 0), (i == 0), 3'(i));
            end
            drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
        end
        idle();
        nchecks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            nfail++;
            $display("FAIL drain_empty got v=%b count=%0d want 0 0", bus.out_valid, bus.count);
        end
    endtask

    task automatic test_ovf_priority();
        for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 8), 1'b0, 3'b001, 1'b0, 1'b0);
        drive(1'b1, 4'hE, 1'b1, 3'b110, 1'b1, 1'b1);
        nchecks++;
        if (bus.ovf !== 1'b1) begin nfail++; $display("FAIL ovf_set_wins got %b want 1", bus.ovf); end
        nchecks++;
        if (bus.count !== 3'd3 || bus.out_s !== 4'd9) begin
            nfail++;
            $display("FAIL ovf_no_bypass got count=%0d head=%h want 3 9", bus.count, bus.out_s);
        end
        drive(1'b0, '0, 1'b0, 3'b000, 1'b0, 1'b1);
        nchecks++;
        if (bus.ovf !== 1'b0) begin nfail++; $display("FAIL ovf_clear got %b want 0", bus.ovf); end
        for (int i = 0; i < 3; i++) begin
            nchecks++;
            if (bus.out_s !== 4'(i + 9)) begin nfail++; $display("FAIL ovf_drain_%0d got %h want %h", i, bus.out_s, 4'(i + 9)); end
            drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) drive(1'b1, 4'(i), 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 3'b011, 1'b0, 1'b0);
        drive(1'b1, 4'hB, 1'b1, 3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 3'($urandom), 1'b1, 1'b0);
            nchecks++;
            if (bus.count !== 3'd2) begin nfail++; $display("FAIL wrap_count_%0d got %0d want 2", i, bus.count); end
            nchecks++;
            if (bus.out_s !== mq[0].s || bus.out_co !== mq[0].co || bus.out_sel !== mq[0].sel) begin
                nfail++;
                $display("FAIL wrap_head_%0d got s=%h co=%b sel=%h want %h %b %h", i,
                         bus.out_s, bus.out_co, bus.out_sel, mq[0].s, mq[0].co, mq[0].sel);
            end
        end
        drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), 4'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 10));
            nchecks++;
            if (bus.count !== 3'(mq.size()) || bus.ovf !== movf
                || bus.in_ready !== (mq.size() != DEPTH) || bus.out_valid !== (mq.size() != 0)) begin
                nfail++;
                $display("FAIL rand_state_%0d got count=%0d ovf=%b ir=%b ov=%b want %0d %b %b %b", i,
                         bus.count, bus.ovf, bus.in_ready, bus.out_valid, mq.size(), movf,
                         (mq.size() != DEPTH), (mq.size() != 0));
            end
            if (mq.size() != 0) begin
                nchecks++;
                if (bus.out_s !== mq[0].s || bus.out_co !== mq[0].co || bus.out_sel !== mq[0].sel
                    || bus.out_zero !== (mq[0].s == 0)) begin
                    nfail++;
                    $display("FAIL rand_head_%0d got s=%h co=%b z=%b sel=%h want %h %b %b %h", i,
                             bus.out_s, bus.out_co, bus.out_zero, bus.out_sel,
                             mq[0].s, mq[0].co, (mq[0].s == 0), mq[0].sel);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        while (mq.size() != 0) drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 4'(i + 1), 1'b0, 3'b000, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0);
        nchecks++;
        if (bus.count !== 3'd3 || bus.ovf !== 1'b1) begin
            nfail++;
            $display("FAIL rst_pre got count=%0d ovf=%b want 3 1", bus.count, bus.ovf);
        end
        rst = 1'b1;
        drive(1'b1, 4'h7, 1'b0, 3'b000, 1'b1, 1'b0);
        rst = 1'b0;
        nchecks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rst_mid got count=%0d v=%b ovf=%b ir=%b want 0 0 0 1",
                     bus.count, bus.out_valid, bus.ovf, bus.in_ready);
        end
    endtask

    initial begin
        nchecks = 0;
        nfail   = 0;
        movf    = 1'b0;
        rst     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.s         = '0;
        bus.co        = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        test_reset();
        test_single();
        test_fill_ovf();
        test_ovf_priority();
        test_wrap();
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
